// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, watermarks and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle registered read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              rd_acc;
    logic              wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always visible; rd_en only acknowledges it.
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule
